// File: rtl/ext_out_port_pkg.sv
// Shared definitions for the external output port and the register file.
// Holds the external-slot address helper and default sizing.
// No logic; imported by the port, its FIFO and the register file.
package ext_out_port_pkg;

    // Default sizing, matching the register file this block sits beside.
    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_N_REG = 8;
    localparam int unsigned DEF_DEPTH = 4;

    // FIFO operation in a cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // The top register-file address is the external (user) slot. Reads of
    // it return user input in the register file; writes land in this block.
    function automatic int unsigned ext_addr(input int unsigned n_reg);
        return n_reg - 1;
    endfunction

    // True when n is a power of two and at least 2.
    function automatic bit depth_ok(input int unsigned n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/ext_out_port_if.sv
// Core-bus and user-side signals of the external output port.
// No latency of its own; pure signal bundle.
// slave = the port itself, master = the core plus the user consumer.
interface ext_out_port_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_REG = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned AW = $clog2(N_REG);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    // Core register bus, shared with the register file.
    logic [AW-1:0]    a;
    logic             ce;
    logic [WIDTH-1:0] in;
    logic             stall;

    // User side: valid/ready stream plus occupancy status.
    logic [WIDTH-1:0] user_data;
    logic             user_valid;
    logic             user_ready;
    logic [LW-1:0]    level;
    logic             full;

    modport slave (
        input  a, ce, in, user_ready,
        output stall, user_data, user_valid, level, full
    );

    modport master (
        output a, ce, in, user_ready,
        input  stall, user_data, user_valid, level, full
    );

endinterface

// File: rtl/ext_out_port_sync_fifo.sv
// Small synchronous FIFO; storage is not reset, only pointers and level.
// Latency: a word pushed at edge N is visible on rdata_o after edge N.
// Backpressure: none internally; the caller must not push when full without a pop.
module sync_fifo
    import ext_out_port_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q,  level_d;
    fifo_op_e         op;

    assign op = fifo_op_e'({push_i, pop_i});

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is 2^PW.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case (op)
            OP_PUSH: level_d = level_q + LW'(1);
            OP_POP:  level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Full/empty come from the level count, never from pointer comparison.
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);

    a_level_bound: assert property (@(posedge clk) disable iff (rst)
        level_q <= LW'(DEPTH));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst)
        pop_i |-> !empty_o);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (push_i && full_o) |-> pop_i);

endmodule

// File: rtl/ext_out_port.sv
// Captures core writes to the external register slot and streams them to the user side.
// Latency: a write accepted at edge N shows user_valid=1 in the cycle after edge N; no bypass.
// Backpressure: stall is combinational; asserted when a slot write arrives while full and no pop.
module ext_out_port
    import ext_out_port_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned N_REG = DEF_N_REG,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    ext_out_port_if.slave  bus
);
    localparam int unsigned   AW    = $clog2(N_REG);
    localparam int unsigned   LW    = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] EXT_A = AW'(ext_addr(N_REG));

    logic             wr_req;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic [LW-1:0]    fifo_level;

    // Address decode, accept rule and stall. A full FIFO still accepts a
    // write when the head leaves in the same cycle; the core holds the bus
    // while stalled, so no retry state is kept here.
    always_comb begin
        wr_req = bus.ce && (bus.a == EXT_A);
        pop    = !fifo_empty && bus.user_ready;
        push   = wr_req && (!fifo_full || pop);
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (bus.in),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.stall      = wr_req && !push;
    assign bus.user_data  = fifo_rdata;
    assign bus.user_valid = !fifo_empty;
    assign bus.level      = fifo_level;
    assign bus.full       = fifo_full;

    a_stall_needs_req: assert property (@(posedge clk) disable iff (rst)
        bus.stall |-> wr_req);
    a_user_hold: assert property (@(posedge clk) disable iff (rst)
        (bus.user_valid && !bus.user_ready) |=>
            (bus.user_valid && $stable(bus.user_data)));
    a_depth_legal: assert property (@(posedge clk)
        depth_ok(DEPTH));

endmodule

// File: tb/tb_ext_out_port.sv
module tb_ext_out_port;
    localparam int unsigned W  = 8;
    localparam int unsigned NR = 8;
    localparam int unsigned D  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] sb_q [$];
    logic [W-1:0] mon_exp;

    ext_out_port_if #(.WIDTH(W), .N_REG(NR), .DEPTH(D)) bus ();

    ext_out_port #(.WIDTH(W), .N_REG(NR), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Scoreboard: every word leaving on the user side must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && bus.user_valid && bus.user_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL pop_data: got %02h, required no pop (scoreboard empty)", bus.user_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if (bus.user_data !== mon_exp) begin
                    errors++;
                    $display("FAIL pop_data: got %02h, required %02h", bus.user_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.a = '0;
        bus.ce = 1'b0;
        bus.in = '0;
        bus.user_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.user_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", bus.user_valid); end
            checks++;
            if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d, required 0", bus.level); end
            checks++;
            if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b, required 0", bus.full); end
            checks++;
            if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, required 0", bus.stall); end
            tick();
        end
    endtask

    task automatic test_fifo_order();
        logic [W-1:0] words [3];
        logic [2:0]   exp_lvl [4];
        words = '{8'h11, 8'h22, 8'h33};
        exp_lvl = '{3'd3, 3'd2, 3'd1, 3'd0};
        for (int i = 0; i < 3; i++) begin
            bus.a = 3'd7;
            bus.ce = 1'b1;
            bus.in = words[i];
            sb_q.push_back(words[i]);
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b0) begin errors++; $display("FAIL order_stall: got %b, required 0", bus.stall); end
            tick();
        end
        bus.ce = 1'b0;
        bus.user_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.level !== exp_lvl[i]) begin errors++; $display("FAIL order_level: got %0d, required %0d", bus.level, exp_lvl[i]); end
            checks++;
            if (bus.user_valid !== (i < 3)) begin errors++; $display("FAIL order_valid: got %b, required %b", bus.user_valid, (i < 3)); end
            tick();
        end
        bus.user_ready = 1'b0;
    endtask

    task automatic test_full_stall();
        int n;
        bus.user_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.a = 3'd7;
            bus.ce = 1'b1;
            bus.in = 8'hA0 + 8'(i);
            sb_q.push_back(8'hA0 + 8'(i));
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b0) begin errors++; $display("FAIL fill_stall: got %b, required 0", bus.stall); end
            tick();
        end
        bus.in = 8'hA4;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b, required 1", bus.stall); end
            checks++;
            if (bus.level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d, required 4", bus.level); end
            checks++;
            if (bus.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b, required 1", bus.full); end
            checks++;
            if (bus.user_data !== 8'hA0) begin errors++; $display("FAIL full_head: got %02h, required a0", bus.user_data); end
            tick();
        end
        bus.user_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL swap_stall: got %b, required 0", bus.stall); end
        sb_q.push_back(8'hA4);
        tick();
        bus.ce = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level !== 3'd4) begin errors++; $display("FAIL swap_level: got %0d, required 4", bus.level); end
        n = 0;
        while (bus.level !== 3'd0 && n < 8) begin
            tick();
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.level !== 3'd0 || n != 4) begin errors++; $display("FAIL drain: level %0d after %0d cycles, required 0 after 4", bus.level, n); end
        checks++;
        if (bus.user_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b, required 0", bus.user_valid); end
        tick();
        bus.user_ready = 1'b0;
    endtask

    task automatic test_other_addr();
        bus.a = 3'd7;
        bus.ce = 1'b1;
        bus.in = 8'h66;
        sb_q.push_back(8'h66);
        tick();
        bus.a = 3'd3;
        bus.in = 8'h55;
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL other_stall: got %b, required 0", bus.stall); end
        tick();
        bus.ce = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level !== 3'd1) begin errors++; $display("FAIL other_level: got %0d, required 1", bus.level); end
        checks++;
        if (bus.user_valid !== 1'b1 || bus.user_data !== 8'h66) begin errors++; $display("FAIL other_head: got valid=%b data=%02h, required valid=1 data=66", bus.user_valid, bus.user_data); end
        tick();
        bus.user_ready = 1'b1;
        tick();
        bus.user_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level !== 3'd0) begin errors++; $display("FAIL other_drain: got %0d, required 0", bus.level); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.user_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.a = 3'd7;
            bus.ce = 1'b1;
            bus.in = 8'(i);
            sb_q.push_back(8'(i));
            @(negedge clk);
            checks++;
            if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_stall: got %b, required 0", bus.stall); end
            checks++;
            if (bus.level !== ((i == 0) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL b2b_level: got %0d, required %0d", bus.level, (i == 0) ? 0 : 1); end
            tick();
        end
        bus.ce = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level !== 3'd1) begin errors++; $display("FAIL b2b_tail: got %0d, required 1", bus.level); end
        tick();
        @(negedge clk);
        checks++;
        if (bus.level !== 3'd0 || sb_q.size() != 0) begin errors++; $display("FAIL b2b_done: level %0d pending %0d, required 0 and 0", bus.level, sb_q.size()); end
        tick();
        bus.user_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.a = 3'd7;
        bus.ce = 1'b1;
        bus.in = 8'hC1;
        sb_q.push_back(8'hC1);
        tick();
        bus.in = 8'hC2;
        sb_q.push_back(8'hC2);
        tick();
        bus.ce = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level !== 3'd2) begin errors++; $display("FAIL pre_rst_level: got %0d, required 2", bus.level); end
        tick();
        bus.user_ready = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        checks++;
        if (bus.level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d, required 0", bus.level); end
        checks++;
        if (bus.user_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", bus.user_valid); end
        checks++;
        if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b, required 0", bus.full); end
        tick();
        bus.user_ready = 1'b0;
        rst = 1'b0;
        bus.a = 3'd7;
        bus.ce = 1'b1;
        bus.in = 8'h7E;
        sb_q.push_back(8'h7E);
        @(negedge clk);
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall: got %b, required 0", bus.stall); end
        tick();
        bus.ce = 1'b0;
        bus.user_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.user_valid !== 1'b1 || bus.user_data !== 8'h7E) begin errors++; $display("FAIL post_rst_data: got valid=%b data=%02h, required valid=1 data=7e", bus.user_valid, bus.user_data); end
        tick();
        bus.user_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.level !== 3'd0 || sb_q.size() != 0) begin errors++; $display("FAIL post_rst_done: level %0d pending %0d, required 0 and 0", bus.level, sb_q.size()); end
        tick();
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_full_stall();
        test_other_addr();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ext_out_port.md
Name: ext_out_port

Overview:
- Write-side counterpart of the external (user) register slot in the register-file address space.
- Address N_REG-1 reads user input in the register file; writes to that address are dropped there.
- This block captures those writes into a small FIFO and presents them to the user/IO side with a valid/ready handshake.
- Sits beside the register file on the same a/ce/in bus and back-pressures the core via stall when the FIFO cannot accept.

Parameters:
- WIDTH, 8, data word width; matches the register file.
- N_REG, 8, register-file address space size; the external address is N_REG-1.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- a  input  $clog2(N_REG)  register address from the core (same bus as the register file).
- ce  input  1  write enable from the core.
- in  input  WIDTH  write data from the core.
- stall  output  1  combinational; high when a write to the external address cannot be accepted this cycle.
- user_data  output  WIDTH  head-of-FIFO word.
- user_valid  output  1  FIFO non-empty.
- user_ready  input  1  consumer accepts user_data this cycle.
- level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.

Behaviour:
- Reset (async, any time including mid-transfer):
  - level=0, read and write pointers = 0, user_valid=0, full=0.
  - Storage contents are not reset; user_data is don't-care while user_valid=0.
- Write request: wr_req = ce && (a == N_REG-1).
- Pop: pop = user_valid && user_ready.
- Accept rule: push = wr_req && (!full || pop). A write is accepted when full provided a pop occurs in the same cycle.
- stall = wr_req && !push, purely combinational, no registered path. The core holds a/ce/in while stall=1. The block adds no retry state of its own.
- Writes to any other address: ignored, stall=0.
- Push: mem[wr_ptr] <= in; wr_ptr increments modulo DEPTH.
- Pop: rd_ptr increments modulo DEPTH.
- Occupancy: level += push - pop. A simultaneous push and pop leaves level unchanged.
- Latency:
  - A word pushed into an empty FIFO at edge N appears with user_valid=1 in the cycle after edge N.
  - There is no same-cycle bypass from in to user_data.
- Handshake:
  - user_data and user_valid are stable while user_valid=1 and user_ready=0.
  - user_ready while user_valid=0 has no effect.
- Ordering: strict FIFO order; no loss or duplication.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from level, not pointer comparison.
- Assertions the verifier checks:
  - level never exceeds DEPTH.
  - No pop when empty.
  - stall implies wr_req.

Decomposition:
- Shared package: ext_addr function/constant (N_REG-1) used by both this block and the register file.
- Sub-module sync_fifo (WIDTH, DEPTH):
  - Ports: clk, rst, push, wdata, pop, rdata, level, full, empty.
  - The top level adds address decode, accept/stall logic and the user handshake.

Test Plan:
- Reset then idle, user_ready=0: user_valid=0, level=0, full=0, stall=0 for 10 cycles.
- Write 0x11, 0x22, 0x33 to address 7 (N_REG=8), then assert user_ready:
  - user_data is 0x11, 0x22, 0x33 on consecutive cycles.
  - level goes 3, 2, 1, 0; user_valid drops after the third pop.
- Five back-to-back writes 0xA0..0xA4, user_ready=0:
  - First four accepted; level=4, full=1.
  - Fifth cycle has stall=1 and the word is held.
  - Raise user_ready: 0xA4 is accepted in the same cycle 0xA0 pops; level stays 4.
- Write 0x55 to address 3 with ce=1: stall=0, level unchanged, user_valid unchanged.
- Write to address 7 with user_ready held at 1 for 12 cycles, data 0..11: words exit in order, pointers wrap past DEPTH, level never exceeds 1.
- Fill to 2 entries, assert rst mid-pop: level=0, user_valid=0 immediately. After rst deasserts, a write of 0x7E reads back as 0x7E.
